// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache miss sequencer.
// Field widths are derived from the default cache geometry (entries, block bits).
package dcache_pkg;

  localparam int DC_NUM_ENTS   = 64;
  localparam int DC_BLOCK_SIZE = 128;
  localparam int DC_OFF_W      = $clog2(DC_BLOCK_SIZE / 8);
  localparam int DC_IDX_W      = $clog2(DC_NUM_ENTS);
  localparam int DC_TAG_W      = 32 - DC_IDX_W - DC_OFF_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_FETCH     = 3'd2,
    ST_REPAIR    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_RESPOND   = 3'd5
  } ctrl_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Bundle of the LSU request, data_cache port and main-memory signals around dcache_ctrl.
// Suffixes (_i/_o) are relative to the controller; master = controller, slave = surrounding system.
interface dcache_ctrl_if #(
  parameter int BLOCK_SIZE = dcache_pkg::DC_BLOCK_SIZE
);
  // Handshakes (req_*, mem_req_*): a transfer happens on a clock edge where valid and ready are
  // both high; once valid is raised its payload stays unchanged until that transfer edge.
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [31:0]           req_addr_i;
  logic [31:0]           req_wdata_i;
  logic                  resp_valid_o;
  logic [31:0]           resp_rdata_o;

  logic                  dc_rd_en_o;
  logic [31:0]           dc_rd_addr_o;
  logic [31:0]           dc_rd_data_i;
  logic                  dc_rd_hit_i;
  logic                  dc_wr_en_o;
  logic [31:0]           dc_wr_addr_o;
  logic [31:0]           dc_wr_data_o;
  logic                  dc_is_repair_o;
  logic [BLOCK_SIZE-1:0] dc_repair_data_o;
  logic                  dc_repair_dirty_o;
  logic                  dc_wr_hit_i;
  logic                  dc_wb_en_i;
  logic [BLOCK_SIZE-1:0] dc_wb_block_i;

  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic                  mem_req_we_o;
  logic [31:0]           mem_req_addr_o;
  logic [BLOCK_SIZE-1:0] mem_req_wdata_o;
  logic                  mem_resp_valid_i;
  logic [BLOCK_SIZE-1:0] mem_resp_data_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o,
    output dc_rd_en_o, dc_rd_addr_o, dc_wr_en_o, dc_wr_addr_o, dc_wr_data_o,
    output dc_is_repair_o, dc_repair_data_o, dc_repair_dirty_o,
    input  dc_rd_data_i, dc_rd_hit_i, dc_wr_hit_i, dc_wb_en_i, dc_wb_block_i,
    output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o,
    input  dc_rd_en_o, dc_rd_addr_o, dc_wr_en_o, dc_wr_addr_o, dc_wr_data_o,
    input  dc_is_repair_o, dc_repair_data_o, dc_repair_dirty_o,
    output dc_rd_data_i, dc_rd_hit_i, dc_wr_hit_i, dc_wb_en_i, dc_wb_block_i,
    input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i
  );

endinterface

// File: rtl/dcache_ctrl.sv
// Blocking miss sequencer: lookup, block fetch, repair install, victim writeback, replay.
// Define DCACHE_CTRL_PERF_EN to add saturating hit/miss/writeback counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_ENTS   = DC_NUM_ENTS,
  parameter int BLOCK_SIZE = DC_BLOCK_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.master bus,
  output ctrl_state_e  state_o
`ifdef DCACHE_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_hits_o,
  output logic [31:0]  perf_misses_o,
  output logic [31:0]  perf_wbs_o
`endif
);

  localparam int OFF_W = $clog2(BLOCK_SIZE / 8);
  localparam int IDX_W = $clog2(NUM_ENTS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;

  ctrl_state_e           state;
  logic                  lat_we;
  logic [31:0]           lat_addr;
  logic                  fetch_wait;
  logic                  replay;
  logic                  first_lookup;

  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  dc_rd_en_q;
  logic                  dc_wr_en_q;
  logic [31:0]           dc_addr_q;
  logic [31:0]           dc_wr_data_q;
  logic                  dc_is_repair_q;
  logic [BLOCK_SIZE-1:0] repair_data_q;
  logic                  mem_req_valid_q;
  logic                  mem_req_we_q;
  logic [31:0]           mem_req_addr_q;
  logic [BLOCK_SIZE-1:0] mem_req_wdata_q;

  logic [TAG_W-1:0]      shadow_tag [NUM_ENTS];
  logic [NUM_ENTS-1:0]   shadow_valid;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [31:0]           blk_addr;
  logic                  lookup_hit;

`ifdef DCACHE_CTRL_PERF_EN
  logic [31:0] hits_q, misses_q, wbs_q;
  assign perf_hits_o   = hits_q;
  assign perf_misses_o = misses_q;
  assign perf_wbs_o    = wbs_q;
`endif

  assign idx        = lat_addr[OFF_W +: IDX_W];
  assign tag        = lat_addr[31 -: TAG_W];
  assign blk_addr   = {lat_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign lookup_hit = lat_we ? bus.dc_wr_hit_i : bus.dc_rd_hit_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      lat_we          <= 1'b0;
      lat_addr        <= '0;
      fetch_wait      <= 1'b0;
      replay          <= 1'b0;
      first_lookup    <= 1'b0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      dc_rd_en_q      <= 1'b0;
      dc_wr_en_q      <= 1'b0;
      dc_addr_q       <= '0;
      dc_wr_data_q    <= '0;
      dc_is_repair_q  <= 1'b0;
      repair_data_q   <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      shadow_valid    <= '0;
      for (int i = 0; i < NUM_ENTS; i++) shadow_tag[i] <= '0;
`ifdef DCACHE_CTRL_PERF_EN
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid_i && req_ready_q) begin
            lat_we       <= bus.req_we_i;
            lat_addr     <= {bus.req_addr_i[31:2], 2'b00};
            dc_addr_q    <= {bus.req_addr_i[31:2], 2'b00};
            dc_wr_data_q <= bus.req_wdata_i;
            dc_rd_en_q   <= ~bus.req_we_i;
            dc_wr_en_q   <= bus.req_we_i;
            req_ready_q  <= 1'b0;
            first_lookup <= 1'b1;
            replay       <= 1'b0;
            state        <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          dc_rd_en_q   <= 1'b0;
          dc_wr_en_q   <= 1'b0;
          first_lookup <= 1'b0;
          if (lookup_hit) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= lat_we ? 32'd0 : bus.dc_rd_data_i;
            state        <= ST_RESPOND;
`ifdef DCACHE_CTRL_PERF_EN
            if (first_lookup) hits_q <= sat_inc(hits_q);
`endif
          end else begin
            // The block was just installed, so a replay can only miss if data_cache disagrees.
            assert (!replay);
            mem_req_valid_q <= 1'b1;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= blk_addr;
            fetch_wait      <= 1'b0;
            state           <= ST_FETCH;
`ifdef DCACHE_CTRL_PERF_EN
            if (first_lookup) misses_q <= sat_inc(misses_q);
`endif
          end
        end
        ST_FETCH: begin
          if (!fetch_wait) begin
            if (bus.mem_req_ready_i) begin
              mem_req_valid_q <= 1'b0;
              fetch_wait      <= 1'b1;
            end
          end else if (bus.mem_resp_valid_i) begin
            repair_data_q  <= bus.mem_resp_data_i;
            dc_addr_q      <= blk_addr;
            dc_wr_en_q     <= 1'b1;
            dc_is_repair_q <= 1'b1;
            state          <= ST_REPAIR;
          end
        end
        ST_REPAIR: begin
          dc_wr_en_q        <= 1'b0;
          dc_is_repair_q    <= 1'b0;
          shadow_tag[idx]   <= tag;
          shadow_valid[idx] <= 1'b1;
          if (bus.dc_wb_en_i) begin
            // Victim address comes from the tag being replaced, read before this update lands.
            assert (shadow_valid[idx]);
            mem_req_valid_q <= 1'b1;
            mem_req_we_q    <= 1'b1;
            mem_req_addr_q  <= {shadow_tag[idx], idx, {OFF_W{1'b0}}};
            mem_req_wdata_q <= bus.dc_wb_block_i;
            state           <= ST_WRITEBACK;
          end else begin
            dc_addr_q  <= lat_addr;
            dc_rd_en_q <= ~lat_we;
            dc_wr_en_q <= lat_we;
            replay     <= 1'b1;
            state      <= ST_LOOKUP;
          end
        end
        ST_WRITEBACK: begin
          if (bus.mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            dc_addr_q       <= lat_addr;
            dc_rd_en_q      <= ~lat_we;
            dc_wr_en_q      <= lat_we;
            replay          <= 1'b1;
            state           <= ST_LOOKUP;
`ifdef DCACHE_CTRL_PERF_EN
            wbs_q <= sat_inc(wbs_q);
`endif
          end
        end
        ST_RESPOND: begin
          req_ready_q <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_o               = state;
  assign bus.req_ready_o       = req_ready_q;
  assign bus.resp_valid_o      = resp_valid_q;
  assign bus.resp_rdata_o      = resp_rdata_q;
  assign bus.dc_rd_en_o        = dc_rd_en_q;
  assign bus.dc_rd_addr_o      = dc_addr_q;
  assign bus.dc_wr_en_o        = dc_wr_en_q;
  assign bus.dc_wr_addr_o      = dc_addr_q;
  assign bus.dc_wr_data_o      = dc_wr_data_q;
  assign bus.dc_is_repair_o    = dc_is_repair_q;
  assign bus.dc_repair_data_o  = repair_data_q;
  assign bus.dc_repair_dirty_o = 1'b0;
  assign bus.mem_req_valid_o   = mem_req_valid_q;
  assign bus.mem_req_we_o      = mem_req_we_q;
  assign bus.mem_req_addr_o    = mem_req_addr_q;
  assign bus.mem_req_wdata_o   = mem_req_wdata_q;

endmodule
